int_ctrl: RTL and testbench

// - Memory-mapped interrupt controller between the interrupt sources (T0_IRQ, T1_IRQ, external interrupt)
//   and the CPU HWInt[5:0] input; it sits on the bridge as a third slave beside the two timers.
// - Latches, masks and prioritises requests, then presents exactly one source at a time to the CPU.
// - Holds that source until the CPU responds and software writes end-of-interrupt (EOI).

---
 rtl/int_ctrl_pkg.sv | 45 ++++
 rtl/int_prio_enc.sv | 22 ++
 rtl/int_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_int_ctrl.sv | 313 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/int_ctrl_pkg.sv
// Shared constants, register map, state encoding and bus payload types
// for the memory-mapped interrupt controller.
package int_ctrl_pkg;

    localparam int unsigned DATA_W   = 32;
    localparam int unsigned ADDR_W   = 30;
    localparam int unsigned ID_W     = 3;
    localparam int unsigned HW_W     = 6;
    localparam int unsigned NSRC_MAX = 6;

    // Bridge decode base (byte address) for this slave
    localparam logic [31:0] INT_CTRL_BASE = 32'h0000_7F40;

    // Register offsets, selected by Addr[3:2]
    localparam logic [1:0] REG_ENABLE  = 2'd0;
    localparam logic [1:0] REG_PENDING = 2'd1;
    localparam logic [1:0] REG_MODE    = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // Controller states
    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_ASSERT  = 2'd1;
    localparam logic [1:0] ST_SERVICE = 2'd2;

    // Priority encoder result: any request plus lowest set index
    typedef struct packed {
        logic            any;
        logic [ID_W-1:0] idx;
    } prio_t;

    // STATUS read word layout
    typedef struct packed {
        logic [1:0]      state;
        logic [24:0]     rsvd_hi;
        logic            valid;
        logic            rsvd_lo;
        logic [ID_W-1:0] cur_id;
    } status_t;

    // One-hot decode of a source id onto the CPU interrupt lines
    function automatic logic [HW_W-1:0] id_onehot(input logic [ID_W-1:0] id);
        return HW_W'(1) << id;
    endfunction

endpackage

// File: rtl/int_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins.
module int_prio_enc
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NSRC = 6
) (
    input  logic [NSRC-1:0] req,
    output prio_t           result
);

    // Scan from the top so the lowest index overwrites last
    always_comb begin
        result = '0;
        for (int i = int'(NSRC) - 1; i >= 0; i--) begin
            if (req[i]) begin
                result.any = 1'b1;
                result.idx = ID_W'(i);
            end
        end
    end

endmodule

// File: rtl/int_ctrl.sv
// Interrupt controller: latches, masks and prioritises source requests and
// presents one source at a time on HWInt until the CPU responds and writes EOI.
module int_ctrl
    import int_ctrl_pkg::*;
#(
    parameter int unsigned NSRC     = 6,
    parameter logic [5:0]  EDGE_RST = 6'b000000
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [29:0]       Addr,
    input  logic              WE,
    input  logic [31:0]       Din,
    output logic [31:0]       Dout,
    input  logic [NSRC-1:0]   irq_src,
    input  logic              int_response,
    output logic [5:0]        HWInt
);

    logic [1:0]      offset;
    logic [NSRC-1:0] wdata;
    logic            wr_enable;
    logic            wr_pending;
    logic            wr_mode;
    logic            wr_status;

    logic [NSRC-1:0] src_q;
    logic [NSRC-1:0] pending;
    logic [NSRC-1:0] enable;
    logic [NSRC-1:0] mode;
    logic [NSRC-1:0] pend_nxt;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] clr;
    logic [NSRC-1:0] eligible;
    logic [NSRC-1:0] cur_sel;
    logic            cur_en;
    logic            eoi_fire;

    logic [1:0]      state;
    logic [1:0]      state_nxt;
    logic [ID_W-1:0] cur_id;
    logic [ID_W-1:0] cur_id_nxt;
    logic            valid;
    logic            valid_nxt;
    logic [HW_W-1:0] hwint_q;
    logic [HW_W-1:0] hwint_nxt;

    prio_t           prio;
    status_t         status;
    logic            unused_bits;

    assign offset     = Addr[3:2];
    assign wdata      = Din[NSRC-1:0];
    assign wr_enable  = WE && (offset == REG_ENABLE);
    assign wr_pending = WE && (offset == REG_PENDING);
    assign wr_mode    = WE && (offset == REG_MODE);
    assign wr_status  = WE && (offset == REG_STATUS);

    // Only Addr[3:2] and the low NSRC data bits carry meaning here
    assign unused_bits = ^{Addr[29:4], Addr[1:0], Din[DATA_W-1:NSRC]};

    assign eligible = pending & enable;
    assign cur_sel  = NSRC'(id_onehot(cur_id));
    assign cur_en   = |(enable & cur_sel);
    assign eoi_fire = wr_status && (state == ST_SERVICE);

    int_prio_enc #(
        .NSRC   (NSRC)
    ) u_prio (
        .req    (eligible),
        .result (prio)
    );

    // Pending update: edge bits set-dominant over W1C/EOI clears, level bits track input
    always_comb begin
        rise = irq_src & ~src_q;
        clr  = '0;
        if (wr_pending) begin
            clr = wdata;
        end
        if (eoi_fire) begin
            clr = clr | cur_sel;
        end
        pend_nxt = (mode & (rise | (pending & ~clr))) | (~mode & irq_src);
    end

    // Next-state logic; the winner is frozen from IDLE until EOI or withdrawal
    always_comb begin
        state_nxt  = state;
        cur_id_nxt = cur_id;
        valid_nxt  = valid;
        case (state)
            ST_IDLE: begin
                if (prio.any) begin
                    cur_id_nxt = prio.idx;
                    valid_nxt  = 1'b1;
                    state_nxt  = ST_ASSERT;
                end
            end
            ST_ASSERT: begin
                if (int_response) begin
                    state_nxt = ST_SERVICE;
                end else if (!cur_en) begin
                    valid_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            ST_SERVICE: begin
                if (eoi_fire) begin
                    valid_nxt = 1'b0;
                    state_nxt = ST_IDLE;
                end
            end
            default: begin
                valid_nxt = 1'b0;
                state_nxt = ST_IDLE;
            end
        endcase
        hwint_nxt = (state_nxt == ST_ASSERT) ? id_onehot(cur_id_nxt) : '0;
    end

    // State register
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Service context and CPU request line
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur_id  <= '0;
            valid   <= 1'b0;
            hwint_q <= '0;
        end else begin
            cur_id  <= cur_id_nxt;
            valid   <= valid_nxt;
            hwint_q <= hwint_nxt;
        end
    end

    // Software-visible registers and the edge-detect history
    always_ff @(posedge clk) begin
        if (!reset) begin
            src_q   <= '0;
            pending <= '0;
            enable  <= '0;
            mode    <= EDGE_RST[NSRC-1:0];
        end else begin
            src_q   <= irq_src;
            pending <= pend_nxt;
            if (wr_enable) begin
                enable <= wdata;
            end
            if (wr_mode) begin
                mode <= wdata;
            end
        end
    end

    assign HWInt = hwint_q;

    // Register read mux
    always_comb begin
        status        = '0;
        status.state  = state;
        status.valid  = valid;
        status.cur_id = cur_id;
        Dout          = '0;
        case (offset)
            REG_ENABLE:  Dout = 32'(enable);
            REG_PENDING: Dout = 32'(pending);
            REG_MODE:    Dout = 32'(mode);
            REG_STATUS:  Dout = status;
        endcase
    end

endmodule

// File: tb/tb_int_ctrl.sv
// Self-checking bench for int_ctrl: directed scenarios plus randomized traffic
// compared against a cycle-level behavioural model of the controller.
module tb_int_ctrl;
    import int_ctrl_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [29:0] Addr;
    logic        WE;
    logic [31:0] Din;
    logic [31:0] Dout;
    logic [5:0]  irq_src;
    logic        int_response;
    logic [5:0]  HWInt;

    int total = 0;
    int bad   = 0;

    // Behavioural model state
    logic [5:0] m_pend, m_en, m_mode, m_prev;
    int         m_phase;   // 0 idle, 1 requesting CPU, 2 CPU servicing
    int         m_id;
    bit         m_valid;

    always #5 clk = ~clk;

    int_ctrl #(.NSRC(6), .EDGE_RST(6'b000000)) dut (
        .clk          (clk),
        .reset        (reset),
        .Addr         (Addr),
        .WE           (WE),
        .Din          (Din),
        .Dout         (Dout),
        .irq_src      (irq_src),
        .int_response (int_response),
        .HWInt        (HWInt)
    );

    initial begin
        #400000;
        $display("FAIL watchdog: time limit reached, bad=%0d", bad);
        $fatal(1, "watchdog");
    end

    function automatic logic [5:0] m_hw();
        return (m_phase == 1) ? (6'd1 << m_id) : 6'd0;
    endfunction

    function automatic logic [31:0] m_status();
        logic [31:0] s;
        s = 32'd0;
        s[31:30] = 2'(m_phase);
        s[4]     = m_valid;
        s[2:0]   = 3'(m_id);
        return s;
    endfunction

    // Apply the controller rules for one clock edge to the model
    task automatic mdl_step();
        logic [5:0] np;
        bit eoi, w1c;
        int w;
        if (!reset) begin
            m_pend = 0; m_en = 0; m_mode = 0; m_prev = 0;
            m_phase = 0; m_id = 0; m_valid = 0;
            return;
        end
        eoi = WE && (Addr[3:2] == 2'd3) && (m_phase == 2);
        for (int i = 0; i < 6; i++) begin
            w1c = WE && (Addr[3:2] == 2'd1) && Din[i];
            if (!m_mode[i])                     np[i] = irq_src[i];
            else if (irq_src[i] && !m_prev[i])  np[i] = 1'b1;
            else if (w1c || (eoi && m_id == i)) np[i] = 1'b0;
            else                                np[i] = m_pend[i];
        end
        if (m_phase == 0) begin
            w = -1;
            for (int i = 5; i >= 0; i--) if (m_pend[i] && m_en[i]) w = i;
            if (w >= 0) begin m_id = w; m_valid = 1; m_phase = 1; end
        end else if (m_phase == 1) begin
            if (int_response) m_phase = 2;
            else if (!m_en[m_id]) begin m_phase = 0; m_valid = 0; end
        end else if (eoi) begin
            m_phase = 0; m_valid = 0;
        end
        if (WE && Addr[3:2] == 2'd0) m_en = Din[5:0];
        if (WE && Addr[3:2] == 2'd2) m_mode = Din[5:0];
        m_pend = np;
        m_prev = irq_src;
    endtask

    task automatic cycle();
        @(posedge clk);
        mdl_step();
        #1;
    endtask

    task automatic wr(input logic [1:0] off, input logic [31:0] d);
        Addr = {26'd0, off, 2'b00};
        Din  = d;
        WE   = 1'b1;
        cycle();
        WE   = 1'b0;
        Din  = 32'd0;
    endtask

    task automatic rd(input logic [1:0] off, output logic [31:0] d);
        WE   = 1'b0;
        Addr = {26'd0, off, 2'b00};
        #1;
        d = Dout;
    endtask

    task automatic pulse_response();
        int_response = 1'b1;
        cycle();
        int_response = 1'b0;
    endtask

    task automatic test_reset_init();
        logic [31:0] d;
        reset = 1'b0; WE = 1'b0; Addr = '0; Din = '0; irq_src = '0; int_response = 1'b0;
        cycle(); cycle();
        reset = 1'b1;
        cycle();
        total++; if (HWInt !== 6'd0) begin bad++; $display("FAIL init_hwint: got %b want 000000", HWInt); end
        rd(REG_STATUS, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL init_status: got %h want 00000000", d); end
    endtask

    task automatic test_edge_basic();
        logic [31:0] d;
        wr(REG_MODE, 32'h1);
        wr(REG_ENABLE, 32'h1);
        irq_src = 6'b000001;
        cycle();
        rd(REG_PENDING, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL edge_pending_set: got %h want 1", d); end
        total++; if (HWInt !== 6'd0) begin bad++; $display("FAIL edge_hwint_early: got %b want 000000", HWInt); end
        cycle();
        total++; if (HWInt !== 6'b000001) begin bad++; $display("FAIL edge_hwint: got %b want 000001", HWInt); end
        pulse_response();
        total++; if (HWInt !== 6'd0) begin bad++; $display("FAIL edge_resp_hwint: got %b want 000000", HWInt); end
        rd(REG_STATUS, d);
        total++; if (d !== 32'h8000_0010) begin bad++; $display("FAIL edge_service_status: got %h want 80000010", d); end
        wr(REG_STATUS, 32'h0);
        rd(REG_PENDING, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_eoi_pending: got %h want 0", d); end
        rd(REG_STATUS, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL edge_eoi_status: got %h want 00000000", d); end
        irq_src = 6'd0;
        cycle();
        total++; if (HWInt !== m_hw()) begin bad++; $display("FAIL edge_idle_hwint: got %b want %b", HWInt, m_hw()); end
    endtask

    task automatic test_level_prio();
        wr(REG_MODE, 32'h0);
        wr(REG_ENABLE, 32'h6);
        irq_src = 6'b000110;
        cycle(); cycle();
        total++; if (HWInt !== 6'b000010) begin bad++; $display("FAIL level_first: got %b want 000010", HWInt); end
        pulse_response();
        wr(REG_STATUS, 32'h0);
        cycle();
        total++; if (HWInt !== 6'b000010) begin bad++; $display("FAIL level_refire: got %b want 000010", HWInt); end
        pulse_response();
        irq_src = 6'b000100;
        cycle();
        wr(REG_STATUS, 32'h0);
        cycle();
        total++; if (HWInt !== 6'b000100) begin bad++; $display("FAIL level_next: got %b want 000100", HWInt); end
        pulse_response();
        irq_src = 6'd0;
        cycle();
        wr(REG_STATUS, 32'h0);
        cycle();
        total++; if (HWInt !== m_hw()) begin bad++; $display("FAIL level_drain: got %b want %b", HWInt, m_hw()); end
    endtask

    task automatic test_eoi_race();
        logic [31:0] d;
        wr(REG_MODE, 32'h4);
        wr(REG_ENABLE, 32'h4);
        irq_src = 6'b000100;
        cycle(); cycle();
        total++; if (HWInt !== 6'b000100) begin bad++; $display("FAIL race_assert: got %b want 000100", HWInt); end
        pulse_response();
        irq_src = 6'd0;
        cycle();
        irq_src = 6'b000100;
        wr(REG_STATUS, 32'h0);
        rd(REG_PENDING, d);
        total++; if (d !== 32'h4) begin bad++; $display("FAIL race_pending_kept: got %h want 4", d); end
        cycle();
        total++; if (HWInt !== 6'b000100) begin bad++; $display("FAIL race_reassert: got %b want 000100", HWInt); end
        pulse_response();
        wr(REG_STATUS, 32'h0);
        rd(REG_PENDING, d);
        total++; if (d !== 32'h0) begin bad++; $display("FAIL race_cleared: got %h want 0", d); end
        irq_src = 6'd0;
        cycle();
    endtask

    task automatic test_withdraw();
        logic [31:0] d;
        wr(REG_MODE, 32'h0);
        wr(REG_ENABLE, 32'h1);
        irq_src = 6'b000001;
        cycle(); cycle();
        total++; if (HWInt !== 6'b000001) begin bad++; $display("FAIL wd_assert: got %b want 000001", HWInt); end
        wr(REG_ENABLE, 32'h0);
        cycle();
        total++; if (HWInt !== 6'd0) begin bad++; $display("FAIL wd_drop: got %b want 000000", HWInt); end
        rd(REG_STATUS, d);
        total++; if (d[4] !== 1'b0 || d[31:30] !== 2'd0) begin bad++; $display("FAIL wd_status: got %h want valid=0 idle", d); end
        wr(REG_ENABLE, 32'h1);
        total++; if (HWInt !== 6'd0) begin bad++; $display("FAIL wd_reen_early: got %b want 000000", HWInt); end
        cycle();
        total++; if (HWInt !== 6'b000001) begin bad++; $display("FAIL wd_reappear: got %b want 000001", HWInt); end
        pulse_response();
        irq_src = 6'd0;
        cycle();
        wr(REG_STATUS, 32'h0);
        cycle();
    endtask

    task automatic test_ignored();
        logic [31:0] d;
        wr(REG_ENABLE, 32'h0);
        wr(REG_MODE, 32'h0);
        irq_src = 6'b000001;
        cycle();
        wr(REG_PENDING, 32'h1);
        rd(REG_PENDING, d);
        total++; if (d !== 32'h1) begin bad++; $display("FAIL ign_w1c_level: got %h want 1", d); end
        wr(REG_STATUS, 32'hFFFF_FFFF);
        rd(REG_STATUS, d);
        total++; if (d !== m_status() || d[31:30] !== 2'd0) begin bad++; $display("FAIL ign_eoi_idle: got %h want %h", d, m_status()); end
        pulse_response();
        rd(REG_STATUS, d);
        total++; if (d[31:30] !== 2'd0 || HWInt !== 6'd0) begin bad++; $display("FAIL ign_resp_idle: status %h hwint %b want idle/000000", d, HWInt); end
        irq_src = 6'd0;
        cycle();
    endtask

    task automatic test_random(input int n);
        logic [31:0] d;
        int r;
        wr(REG_MODE, $urandom);
        wr(REG_ENABLE, $urandom);
        for (int k = 0; k < n; k++) begin
            irq_src      = 6'($urandom);
            int_response = ($urandom_range(0, 3) == 0);
            r = $urandom_range(0, 7);
            if (r < 2) begin
                Addr = {26'd0, REG_STATUS, 2'b00}; Din = $urandom; WE = 1'b1;
            end else if (r == 2) begin
                Addr = {26'd0, REG_PENDING, 2'b00}; Din = $urandom; WE = 1'b1;
            end else begin
                WE = 1'b0;
            end
            cycle();
            WE = 1'b0; int_response = 1'b0;
            total++; if (HWInt !== m_hw()) begin bad++; $display("FAIL rnd_hwint k=%0d: got %b want %b", k, HWInt, m_hw()); end
            rd(REG_PENDING, d);
            total++; if (d !== 32'(m_pend)) begin bad++; $display("FAIL rnd_pending k=%0d: got %h want %h", k, d, 32'(m_pend)); end
            rd(REG_STATUS, d);
            total++; if (d !== m_status()) begin bad++; $display("FAIL rnd_status k=%0d: got %h want %h", k, d, m_status()); end
        end
        irq_src = 6'd0;
        cycle(); cycle();
    endtask

    task automatic test_reset_service();
        logic [31:0] d;
        wr(REG_MODE, 32'h2A);
        wr(REG_ENABLE, 32'h1);
        irq_src = 6'b000001;
        cycle(); cycle();
        pulse_response();
        rd(REG_STATUS, d);
        total++; if (d[31:30] !== 2'd2) begin bad++; $display("FAIL rst_pre_service: got %h want state 2", d); end
        reset = 1'b0;
        cycle(); cycle();
        total++; if (HWInt !== 6'd0) begin bad++; $display("FAIL rst_hwint: got %b want 000000", HWInt); end
        rd(REG_ENABLE, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_enable: got %h want 0", d); end
        rd(REG_PENDING, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_pending: got %h want 0", d); end
        rd(REG_MODE, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_mode: got %h want 0", d); end
        rd(REG_STATUS, d);
        total++; if (d !== 32'd0) begin bad++; $display("FAIL rst_status: got %h want 0", d); end
        reset = 1'b1;
        irq_src = 6'd0;
        cycle();
    endtask

    initial begin
        test_reset_init();
        test_edge_basic();
        test_level_prio();
        test_eoi_race();
        test_withdraw();
        test_ignored();
        test_random(400);
        test_random(400);
        test_reset_service();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
